// File: rtl/sand_step_scheduler.sv
// Step sequencer for the sandpile array: vsync-aligned new_frame pulses plus a small drop FIFO.
// Define SAND_AUTO_DROP_EN to inject a centre grain on steps that find the drop FIFO empty.
module sand_step_scheduler #(
  parameter int COORD_W    = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vga_vs_i,
  input  logic               run_i,
  input  logic               single_step_i,
  input  logic [3:0]         steps_per_frame_i,
  input  logic [COORD_W-1:0] resolution_i,
  input  logic               array_done_i,
  input  logic               drop_req_i,
  input  logic [COORD_W-1:0] drop_x_i,
  input  logic [COORD_W-1:0] drop_y_i,
  output logic               drop_ready_o,
  output logic               new_frame_o,
  output logic               drop_o,
  output logic [COORD_W-1:0] drop_x_o,
  output logic [COORD_W-1:0] drop_y_o,
  output logic               busy_o,
  output logic [CNT_W-1:0]   step_count_o,
  output logic               overrun_o,
  output logic               bad_drop_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STEP, WAIT_DONE} state_t;

  state_t state, state_next;
  logic [3:0] remaining, remaining_next;
  logic vs_d1, vs_d2, vs_fall;
  logic alive;
  logic [CNT_W-1:0] step_count;
  logic overrun, bad_drop;
  logic [COORD_W-1:0] last_x, last_y;

  logic [COORD_W-1:0] fifo_x [FIFO_DEPTH];
  logic [COORD_W-1:0] fifo_y [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic fifo_empty, fifo_full, push, in_range, store, pop, in_step;
  logic drop_now;
  logic [COORD_W-1:0] cand_x, cand_y;

  assign vs_fall    = vs_d2 & ~vs_d1;
  assign in_step    = (state == STEP);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  // Ready looks only at the registered count, so a pop while full does not open it early.
  assign drop_ready_o = alive & ~fifo_full;
  assign push     = drop_req_i & drop_ready_o;
  assign in_range = (drop_x_i < resolution_i) && (drop_y_i < resolution_i);
  assign store    = push & in_range;
  assign pop      = in_step & ~fifo_empty;

`ifdef SAND_AUTO_DROP_EN
  assign drop_now = in_step;
  assign cand_x   = fifo_empty ? (resolution_i >> 1) : fifo_x[rd_ptr];
  assign cand_y   = fifo_empty ? (resolution_i >> 1) : fifo_y[rd_ptr];
`else
  assign drop_now = pop;
  assign cand_x   = fifo_x[rd_ptr];
  assign cand_y   = fifo_y[rd_ptr];
`endif

  assign new_frame_o  = in_step;
  assign busy_o       = (state != IDLE);
  assign drop_o       = drop_now;
  assign drop_x_o     = drop_now ? cand_x : last_x;
  assign drop_y_o     = drop_now ? cand_y : last_y;
  assign step_count_o = step_count;
  assign overrun_o    = overrun;
  assign bad_drop_o   = bad_drop;

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (vs_fall && run_i && (steps_per_frame_i != 4'd0)) begin
          remaining_next = steps_per_frame_i;
          state_next     = STEP;
        end else if (single_step_i) begin
          remaining_next = 4'd1;
          state_next     = STEP;
        end
      end
      STEP: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (array_done_i) begin
          remaining_next = remaining - 4'd1;
          state_next     = (remaining_next != 4'd0) ? STEP : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // vsync idles high, so the sync pair resets to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= 4'd0;
      vs_d1      <= 1'b1;
      vs_d2      <= 1'b1;
      alive      <= 1'b0;
      step_count <= '0;
      overrun    <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      vs_d1     <= vga_vs_i;
      vs_d2     <= vs_d1;
      alive     <= 1'b1;
      if (in_step) step_count <= step_count + CNT_W'(1);
      if (vs_fall && busy_o) overrun <= 1'b1;
      if (drop_now) begin
        last_x <= cand_x;
        last_y <= cand_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bad_drop <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (store && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!store && pop) count <= count - (PTR_W+1)'(1);
      if (push && !in_range)  bad_drop <= 1'b1;
    end
  end

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (store) begin
      fifo_x[wr_ptr] <= drop_x_i;
      fifo_y[wr_ptr] <= drop_y_i;
    end
  end

endmodule

// File: doc/sand_step_scheduler.md
Name: sand_step_scheduler

Overview:
Controller that sequences the sandpile array (macro_sand_array). It issues new_frame step pulses aligned to the VGA vertical sync so the display never shows a half-updated grid. It also buffers external drop requests in a small FIFO and injects at most one drop per step. It sits between the input/drop sources and the array control inputs, next to top_vga_sandpile.

Parameters:
COORD_W, 9, width of drop coordinates and resolution (matches array drop_x/drop_y/resolution)
FIFO_DEPTH, 4, drop request FIFO entries (power of two, >=2)
CNT_W, 16, width of step counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
vga_vs_i  input  1  VGA vsync (active-low pulse), from VGA controller
run_i  input  1  level; 1 = free-running steps each frame
single_step_i  input  1  one-cycle pulse; request one step while idle
steps_per_frame_i  input  4  steps issued per vsync while running; 0 = none
resolution_i  input  COORD_W  active grid size; drops validated against it
array_done_i  input  1  one-cycle pulse from array: current step finished
drop_req_i  input  1  drop request valid
drop_x_i  input  COORD_W  drop column
drop_y_i  input  COORD_W  drop row
drop_ready_o  output  1  FIFO can accept (valid/ready handshake)
new_frame_o  output  1  one-cycle step pulse to array new_frame_i
drop_o  output  1  one-cycle drop pulse to array drop_i, coincident with new_frame_o
drop_x_o  output  COORD_W  drop column to array
drop_y_o  output  COORD_W  drop row to array
busy_o  output  1  1 while a step sequence is in progress
step_count_o  output  CNT_W  total steps issued, wraps
overrun_o  output  1  sticky: vsync arrived while busy
bad_drop_o  output  1  sticky: rejected out-of-range drop

Behaviour:
- Reset: every output 0, except drop_ready_o=1 when out of reset. FIFO is emptied, FSM goes to IDLE, step counter and remaining counter are cleared. Sticky flags are cleared only by reset.
- vga_vs_i is registered. vs_fall = previous 1, current 0 (one-cycle event, 1-cycle latency).
- FSM states: IDLE, STEP, WAIT_DONE.
  - IDLE: if vs_fall && run_i && steps_per_frame_i!=0, then remaining<=steps_per_frame_i and go to STEP.
  - IDLE: else if single_step_i, then remaining<=1 and go to STEP.
  - IDLE: vs_fall takes priority over single_step_i in the same cycle. A single_step_i that loses to vs_fall is discarded.
  - STEP (exactly 1 cycle): new_frame_o=1 (registered output, asserted the cycle the FSM is in STEP). If the FIFO is non-empty, drop_o=1 with the head coordinates, and the head is popped. Then go to WAIT_DONE. step_count_o increments, wrapping at 2^CNT_W.
  - WAIT_DONE: on array_done_i, remaining-=1. If the result is !=0, go to STEP; else go to IDLE.
  - array_done_i outside WAIT_DONE is ignored.
- busy_o=1 in STEP and WAIT_DONE.
- vs_fall while busy_o=1 sets overrun_o. The vsync is not queued; the current sequence continues.
- run_i deassertion mid-sequence: the current sequence completes and no new sequence starts.
- single_step_i while busy is ignored.
- drop_x_o/drop_y_o hold their last value when drop_o=0.
- FIFO: a push occurs when drop_req_i && drop_ready_o. drop_ready_o = !full, computed from the registered count only, so when full a same-cycle pop does not raise ready. Simultaneous push and pop when not full leaves the count unchanged.
- Drop validation happens at push time against the current resolution_i. If drop_x_i>=resolution_i or drop_y_i>=resolution_i, the request is accepted by the handshake but not stored, and bad_drop_o is set. Changing resolution_i later does not revalidate stored entries.
- Reset mid-sequence: immediate return to IDLE. No pulse is emitted in the reset cycle.

Optional Feature:
SAND_AUTO_DROP_EN
- Defined: in STEP with the FIFO empty, drop_o=1 with drop_x_o=drop_y_o=resolution_i>>1 (centre grain, the classic sandpile seed).
- Undefined: STEP with the FIFO empty gives drop_o=0.
- FIFO entries always take precedence over the auto drop.

Test Plan:
1. Reset, run_i=1, steps_per_frame_i=3, array_done_i pulsed 5 cycles after each new_frame_o, one vsync fall -> exactly 3 new_frame_o pulses, step_count_o=3, busy_o returns to 0, overrun_o=0.
2. Push (5,7), (31,0), (2,2) with resolution_i=32, then 4 single steps -> drop_o pulses carry (5,7), (31,0), (2,2) in order. The 4th step has drop_o=0, or with SAND_AUTO_DROP_EN set, coordinates (16,16).
3. Push 5 requests back-to-back with no steps -> the first 4 are accepted, drop_ready_o=0 on the 5th, and the 5th is held until a pop. After the pop, the 5th is accepted the following cycle.
4. resolution_i=16, push (16,3) -> bad_drop_o=1, FIFO stays empty. A later push of (15,15) is accepted and stored.
5. steps_per_frame_i=2, array_done_i withheld, second vsync fall -> overrun_o=1 and no extra sequence starts. After 2 done pulses, step_count_o=2.
6. Assert rst_n=0 during WAIT_DONE with 2 FIFO entries -> all outputs 0, FIFO empty. After release, a single step gives drop_o=0 (no auto drop).
